fir_chan_sched: RTL and testbench
=================================

# fir_chan_sched

Shared-engine scheduler for the 3-tap smoothing FIR in the HR/SpO2 front end. It accepts red and IR sample streams through per-channel holding registers and arbitrates them round-robin onto one multi-cycle multiply-accumulate engine. Per-channel tap history is kept locally, and each result is returned tagged with its channel. It sits between the ADC sample demux and the HR/SpO2 peak-detection logic, replacing two independent filter instances.

## Interface
- DW, 8, sample and result width (unsigned)
- RR_FIRST, 0, channel granted first after reset when both are pending (0 = red, 1 = IR)

- Clk  in  1  system clock, rising edge
- Rst  in  1  asynchronous, active-high reset
- ida_red  in  DW  red sample
- iflag_red  in  1  red sample valid, single-cycle strobe
- ida_ir  in  DW  IR sample
- iflag_ir  in  1  IR sample valid, single-cycle strobe
- sclr  in  1  synchronous clear: histories, pending registers, engine
- oda  out  DW  filtered result
- ochan  out  1  channel of oda (0 red, 1 IR)
- oflag  out  1  result valid, one-cycle pulse
- busy  out  1  engine not in IDLE
- ovf_red  out  1  one-cycle pulse: a pending red sample was overwritten
- ovf_ir  out  1  one-cycle pulse: a pending IR sample was overwritten

## Operation
- Per channel c there is a pending bit and a DW data register.
  - iflag_c at an edge loads the data register and sets pending.
- Per channel there is a history x0 (newest), x1, x2, each DW bits. All are 0 after reset or sclr.
- Arbitration happens when the FSM is in IDLE, or in DIV with something pending.
  - Only one channel pending: grant it.
  - Both pending: grant the channel not granted last. The pointer resets so that RR_FIRST wins the first tie.
- On grant:
  - clear that channel's pending bit and latch its channel id;
  - shift its history: x2<=x1, x1<=x0, x0<=pending data.
- FSM states: IDLE, TAP0, TAP1, TAP2, DIV.
  - IDLE -> TAP0 on grant.
  - TAP0: acc <= 7*x0.
  - TAP1: acc += 2*x1.
  - TAP2: acc += x2.
  - DIV: oda <= acc/10 (truncating), ochan <= latched id, oflag <= 1. Then go to TAP0 if a grant occurs, else IDLE.
- acc is DW+4 bits unsigned. The maximum 10*(2^DW-1) divides back into DW bits, so no saturation is needed.
- Overflow: iflag_c while pending_c is set and c is not granted at that edge overwrites the data. ovf_c pulses; the older sample is lost.
- Arrival on the same edge as grant of c: the grant takes the old data, the new sample becomes pending, and ovf_c does not fire.
- sclr: has priority over all sample activity.
  - Returns the FSM to IDLE, clears acc, histories, pendings and the rr pointer.
  - The in-flight result is discarded; no oflag.
  - Samples arriving with sclr are dropped.

## Timing
- Reset values: oda=0, ochan=0, oflag=0, busy=0, ovf_red=0, ovf_ir=0; FSM in IDLE; all histories and pendings 0.
- Sample strobe at edge E0, engine idle:
  - grant at E1;
  - TAP0/TAP1/TAP2/DIV occupy E1..E4 (busy high);
  - result registered at E5, so oflag is high in the cycle after E5.
  - Latency is 5 edges.
- Sustained throughput: one result per 4 cycles, back-to-back when pending (DIV -> TAP0).
- Simultaneous red and IR strobes at E0: first result at E5, second at E9, with busy continuously high.
- Per-channel input rate must be at most one sample per 8 cycles to guarantee no ovf under full dual-channel load.

## Configuration
- FIR_SCHED_OVF_CNT_EN defined: adds outputs ovf_cnt_red and ovf_cnt_ir (8 bits each).
  - Each is a saturating count (stops at 255) of its ovf pulses.
  - Cleared by Rst and sclr.
- Not defined: those ports and counters are absent. ovf_red and ovf_ir pulses still exist.

## Test plan
- Reset, then red 100 at E0 -> oflag after E5, oda=70, ochan=0. Red 50 next -> oda=55 (7*50+2*100).
- Red and IR strobes on the same edge (red 100, IR 10) -> red oda=70 at E5, IR oda=7 at E9, busy high E1..E8.
- Three red samples of 255 spaced 8 cycles apart -> third result oda=255, with no overflow of acc width.
- Two red strobes 1 cycle apart while IR is in progress -> ovf_red pulses once and only the second sample is filtered. With FIR_SCHED_OVF_CNT_EN, ovf_cnt_red=1.
- sclr asserted during TAP1 -> no oflag, busy low next cycle; next red 20 -> oda=14 (history was zeroed).
- Three alternating tie cycles -> grant order follows RR_FIRST, then alternates strictly; Rst mid-operation drops all outputs to their reset values immediately.

Source files
------------

// File: rtl/fir_chan_sched.sv
// fir_chan_sched: round-robin scheduler that time-shares one 3-tap FIR
// multiply-accumulate engine between the red and IR sample channels.
// Each result is y = (7*x0 + 2*x1 + x2) / 10 and is tagged with its channel.
// Optional feature macro: FIR_SCHED_OVF_CNT_EN adds saturating overflow
// counters ovf_cnt_red / ovf_cnt_ir.
//
// Handshake: iflag_* are single-cycle strobes with no back-pressure. A sample
// waits in its channel's pending register until granted. A new strobe that
// lands on an ungranted pending sample overwrites it and pulses ovf_*.
// oflag is a one-cycle valid for oda/ochan; the consumer cannot stall it.
module fir_chan_sched #(
    parameter int DW       = 8,
    parameter bit RR_FIRST = 1'b0
) (
    input  logic          Clk,
    input  logic          Rst,
    input  logic [DW-1:0] ida_red,
    input  logic          iflag_red,
    input  logic [DW-1:0] ida_ir,
    input  logic          iflag_ir,
    input  logic          sclr,
    output logic [DW-1:0] oda,
    output logic          ochan,
    output logic          oflag,
    output logic          busy,
    output logic          ovf_red,
    output logic          ovf_ir
`ifdef FIR_SCHED_OVF_CNT_EN
    ,
    output logic [7:0]    ovf_cnt_red,
    output logic [7:0]    ovf_cnt_ir
`endif
);

    localparam int AW = DW + 4;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_TAP0 = 3'd1,
        S_TAP1 = 3'd2,
        S_TAP2 = 3'd3,
        S_DIV  = 3'd4
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;

    logic          r_pend_red, r_pend_ir;
    logic [DW-1:0] r_data_red, r_data_ir;
    logic [DW-1:0] r_red_x0, r_red_x1, r_red_x2;
    logic [DW-1:0] r_ir_x0, r_ir_x1, r_ir_x2;
    logic          r_chan;
    logic          r_last_ir;
    logic [AW-1:0] r_acc;
    logic [DW-1:0] r_oda;
    logic          r_ochan, r_oflag;
    logic          r_ovf_red, r_ovf_ir;

    logic          w_arb_en, w_grant_red, w_grant_ir, w_grant;
    logic          w_ovf_red, w_ovf_ir;
    logic [AW-1:0] w_x0e, w_x1e, w_x2e;

    // Arbitration: only in IDLE or DIV; a tie goes to the channel not granted last.
    always_comb begin
        w_arb_en    = (r_state == S_IDLE) || (r_state == S_DIV);
        w_grant_red = w_arb_en && !sclr && r_pend_red && (!r_pend_ir || r_last_ir);
        w_grant_ir  = w_arb_en && !sclr && r_pend_ir && (!r_pend_red || !r_last_ir);
        w_grant     = w_grant_red || w_grant_ir;
        w_ovf_red   = iflag_red && r_pend_red && !w_grant_red && !sclr;
        w_ovf_ir    = iflag_ir && r_pend_ir && !w_grant_ir && !sclr;
        w_x0e       = r_chan ? AW'(r_ir_x0) : AW'(r_red_x0);
        w_x1e       = r_chan ? AW'(r_ir_x1) : AW'(r_red_x1);
        w_x2e       = r_chan ? AW'(r_ir_x2) : AW'(r_red_x2);
    end

    // FSM state register.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    // FSM next state: fixed TAP0..TAP2, DIV walk, with back-to-back restart from DIV.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_grant) w_state_nxt = S_TAP0;
            S_TAP0:  w_state_nxt = S_TAP1;
            S_TAP1:  w_state_nxt = S_TAP2;
            S_TAP2:  w_state_nxt = S_DIV;
            S_DIV:   w_state_nxt = w_grant ? S_TAP0 : S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
        if (sclr) w_state_nxt = S_IDLE;
    end

    // Pending registers: a new strobe always loads; a grant alone clears pending.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_pend_red <= 1'b0;
            r_pend_ir  <= 1'b0;
            r_data_red <= '0;
            r_data_ir  <= '0;
        end else if (sclr) begin
            r_pend_red <= 1'b0;
            r_pend_ir  <= 1'b0;
        end else begin
            if (iflag_red) begin
                r_data_red <= ida_red;
                r_pend_red <= 1'b1;
            end else if (w_grant_red) begin
                r_pend_red <= 1'b0;
            end
            if (iflag_ir) begin
                r_data_ir <= ida_ir;
                r_pend_ir <= 1'b1;
            end else if (w_grant_ir) begin
                r_pend_ir <= 1'b0;
            end
        end
    end

    // Tap histories, channel latch and round-robin pointer update on grant.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_red_x0 <= '0; r_red_x1 <= '0; r_red_x2 <= '0;
            r_ir_x0  <= '0; r_ir_x1  <= '0; r_ir_x2  <= '0;
            r_chan    <= 1'b0;
            r_last_ir <= ~RR_FIRST;
        end else if (sclr) begin
            r_red_x0 <= '0; r_red_x1 <= '0; r_red_x2 <= '0;
            r_ir_x0  <= '0; r_ir_x1  <= '0; r_ir_x2  <= '0;
            r_last_ir <= ~RR_FIRST;
        end else if (w_grant_red) begin
            r_red_x2  <= r_red_x1;
            r_red_x1  <= r_red_x0;
            r_red_x0  <= r_data_red;
            r_chan    <= 1'b0;
            r_last_ir <= 1'b0;
        end else if (w_grant_ir) begin
            r_ir_x2   <= r_ir_x1;
            r_ir_x1   <= r_ir_x0;
            r_ir_x0   <= r_data_ir;
            r_chan    <= 1'b1;
            r_last_ir <= 1'b1;
        end
    end

    // MAC engine and result register; oflag is a single-cycle pulse from DIV.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_acc   <= '0;
            r_oda   <= '0;
            r_ochan <= 1'b0;
            r_oflag <= 1'b0;
        end else begin
            r_oflag <= 1'b0;
            if (sclr) begin
                r_acc <= '0;
            end else begin
                case (r_state)
                    S_TAP0: r_acc <= w_x0e * AW'(7);
                    S_TAP1: r_acc <= r_acc + (w_x1e << 1);
                    S_TAP2: r_acc <= r_acc + w_x2e;
                    S_DIV: begin
                        r_oda   <= DW'(r_acc / AW'(10));
                        r_ochan <= r_chan;
                        r_oflag <= 1'b1;
                    end
                    default: r_acc <= r_acc;
                endcase
            end
        end
    end

    // Overflow pulses, registered so they appear the cycle after the lost sample.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_ovf_red <= 1'b0;
            r_ovf_ir  <= 1'b0;
        end else begin
            r_ovf_red <= w_ovf_red;
            r_ovf_ir  <= w_ovf_ir;
        end
    end

`ifdef FIR_SCHED_OVF_CNT_EN
    logic [7:0] r_cnt_red, r_cnt_ir;

    // Saturating overflow counters.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_cnt_red <= '0;
            r_cnt_ir  <= '0;
        end else if (sclr) begin
            r_cnt_red <= '0;
            r_cnt_ir  <= '0;
        end else begin
            if (w_ovf_red && r_cnt_red != 8'hFF) r_cnt_red <= r_cnt_red + 8'd1;
            if (w_ovf_ir && r_cnt_ir != 8'hFF)   r_cnt_ir  <= r_cnt_ir + 8'd1;
        end
    end

    assign ovf_cnt_red = r_cnt_red;
    assign ovf_cnt_ir  = r_cnt_ir;
`endif

    assign oda     = r_oda;
    assign ochan   = r_ochan;
    assign oflag   = r_oflag;
    assign busy    = (r_state != S_IDLE);
    assign ovf_red = r_ovf_red;
    assign ovf_ir  = r_ovf_ir;

endmodule

// File: tb/tb_fir_chan_sched.sv
// Directed bench for fir_chan_sched with hand-computed FIR results.
module tb_fir_chan_sched;

    localparam int DW = 8;

    logic          Clk = 1'b0;
    logic          Rst = 1'b1;
    logic [DW-1:0] ida_red = '0;
    logic          iflag_red = 1'b0;
    logic [DW-1:0] ida_ir = '0;
    logic          iflag_ir = 1'b0;
    logic          sclr = 1'b0;
    logic [DW-1:0] oda;
    logic          ochan, oflag, busy, ovf_red, ovf_ir;
`ifdef FIR_SCHED_OVF_CNT_EN
    logic [7:0]    ovf_cnt_red, ovf_cnt_ir;
`endif

    int checks = 0;
    int errors = 0;

    fir_chan_sched #(.DW(DW), .RR_FIRST(1'b0)) dut (
        .Clk(Clk), .Rst(Rst),
        .ida_red(ida_red), .iflag_red(iflag_red),
        .ida_ir(ida_ir), .iflag_ir(iflag_ir),
        .sclr(sclr),
        .oda(oda), .ochan(ochan), .oflag(oflag), .busy(busy),
        .ovf_red(ovf_red), .ovf_ir(ovf_ir)
`ifdef FIR_SCHED_OVF_CNT_EN
        , .ovf_cnt_red(ovf_cnt_red), .ovf_cnt_ir(ovf_cnt_ir)
`endif
    );

    // Clock
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one edge; inputs change and outputs are sampled 1ns after it.
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Ticks until oflag is seen (bounded); n = edges taken, 99 on timeout.
    task automatic wait_oflag(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!oflag && n < 30);
        if (!oflag) n = 99;
    endtask

    task automatic strobe(input logic r, input int rv, input logic i, input int iv);
        iflag_red = r;  ida_red = DW'(rv);
        iflag_ir  = i;  ida_ir  = DW'(iv);
        tick();
        iflag_red = 1'b0;
        iflag_ir  = 1'b0;
    endtask

    task automatic do_sclr();
        sclr = 1'b1;
        tick();
        sclr = 1'b0;
    endtask

    initial begin : stim
        int n;
        int seen;

        // Reset state
        Rst = 1'b1;
        tick(); tick();
        check("rst_oda", oda, 0);
        check("rst_ochan", ochan, 0);
        check("rst_oflag", oflag, 0);
        check("rst_busy", busy, 0);
        check("rst_ovf_red", ovf_red, 0);
        check("rst_ovf_ir", ovf_ir, 0);
`ifdef FIR_SCHED_OVF_CNT_EN
        check("rst_cnt_red", ovf_cnt_red, 0);
`endif
        Rst = 1'b0;
        tick();

        // Single red sample: latency 5, 7*100/10 = 70
        strobe(1'b1, 100, 1'b0, 0);
        tick();
        check("t1_busy_e1", busy, 1);
        wait_oflag(n);
        check("t1_latency", n + 1, 5);
        check("t1_oda", oda, 70);
        check("t1_ochan", ochan, 0);
        tick();
        check("t1_oflag_pulse", oflag, 0);
        // Red 50 next: (7*50 + 2*100)/10 = 55
        strobe(1'b1, 50, 1'b0, 0);
        wait_oflag(n);
        check("t2_latency", n, 5);
        check("t2_oda", oda, 55);

        // Simultaneous red 100 / IR 10 from cleared histories
        do_sclr();
        strobe(1'b1, 100, 1'b1, 10);
        for (int k = 1; k <= 9; k++) begin
            tick();
            if (k <= 8) check($sformatf("tie_busy_e%0d", k), busy, 1);
            if (k == 5) begin
                check("tie_red_flag", oflag, 1);
                check("tie_red_oda", oda, 70);
                check("tie_red_chan", ochan, 0);
            end
            if (k == 9) begin
                check("tie_ir_flag", oflag, 1);
                check("tie_ir_oda", oda, 7);
                check("tie_ir_chan", ochan, 1);
                check("tie_idle_after", busy, 0);
            end
        end

        // Three full-scale red samples: 178, 229, 255
        do_sclr();
        strobe(1'b1, 255, 1'b0, 0);
        wait_oflag(n);
        check("fs1_oda", oda, 178);
        tick(); tick();
        strobe(1'b1, 255, 1'b0, 0);
        wait_oflag(n);
        check("fs2_oda", oda, 229);
        tick(); tick();
        strobe(1'b1, 255, 1'b0, 0);
        wait_oflag(n);
        check("fs3_oda", oda, 255);
        check("fs3_no_ovf", ovf_red, 0);

        // Red overwrite while IR runs: only red 30 is filtered -> 21
        do_sclr();
        strobe(1'b0, 0, 1'b1, 10);     // E0
        tick();                        // E1 grant IR
        strobe(1'b1, 40, 1'b0, 0);     // E2 red pending
        strobe(1'b1, 30, 1'b0, 0);     // E3 overwrite
        check("ovf_pulse", ovf_red, 1);
        check("ovf_ir_quiet", ovf_ir, 0);
        tick();                        // E4
        check("ovf_one_cycle", ovf_red, 0);
        tick();                        // E5
        check("ovf_ir_oda", oda, 7);
        check("ovf_ir_chan", ochan, 1);
        wait_oflag(n);
        check("ovf_red_latency", n, 4);
        check("ovf_red_oda", oda, 21);
        check("ovf_red_chan", ochan, 0);
`ifdef FIR_SCHED_OVF_CNT_EN
        check("ovf_cnt_red", ovf_cnt_red, 1);
        check("ovf_cnt_ir", ovf_cnt_ir, 0);
`endif
        seen = 0;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (oflag) seen++;
        end
        check("ovf_no_extra_result", seen, 0);

        // sclr during TAP1 discards the result and zeroes history
        strobe(1'b1, 99, 1'b0, 0);     // E0
        tick();                        // E1 grant
        tick();                        // E2 -> TAP1
        check("sclr_busy_before", busy, 1);
        do_sclr();                     // E3
        check("sclr_busy_after", busy, 0);
        seen = 0;
        for (int k = 0; k < 8; k++) begin
            if (oflag) seen++;
            tick();
        end
        check("sclr_no_oflag", seen, 0);
        strobe(1'b1, 20, 1'b0, 0);
        wait_oflag(n);
        check("sclr_next_oda", oda, 14);

        // Three tie rounds: red, IR, red, IR, red, IR
        do_sclr();
        for (int r = 0; r < 3; r++) begin
            strobe(1'b1, 10, 1'b1, 20);
            wait_oflag(n);
            check($sformatf("rr%0d_first_lat", r), n, 5);
            check($sformatf("rr%0d_first_chan", r), ochan, 0);
            check($sformatf("rr%0d_first_oda", r), oda, (r == 0) ? 7 : (r == 1) ? 9 : 10);
            wait_oflag(n);
            check($sformatf("rr%0d_second_lat", r), n, 4);
            check($sformatf("rr%0d_second_chan", r), ochan, 1);
            check($sformatf("rr%0d_second_oda", r), oda, (r == 0) ? 14 : (r == 1) ? 18 : 20);
            tick(); tick();
        end

        // Asynchronous reset mid-operation
        strobe(1'b1, 50, 1'b0, 0);
        tick(); tick();
        check("pre_rst_busy", busy, 1);
        #2 Rst = 1'b1;
        #1;
        check("arst_oda", oda, 0);
        check("arst_ochan", ochan, 0);
        check("arst_oflag", oflag, 0);
        check("arst_busy", busy, 0);
        check("arst_ovf_red", ovf_red, 0);
        tick();
        Rst = 1'b0;
        tick();
        check("post_rst_busy", busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
